ctrl_seq: RTL and testbench

- Sequenced successor to the combinational control decoder. It decodes each 9-bit instruction's opcode/mode into a registered control vector, one cycle after the instruction is accepted.
- Adds a memory-wait state machine for LOD, branch resolution from ALU flags, post-branch flush bubbles, a PC stall output and illegal-encoding detection.
- Sits between instruction fetch and the register file/ALU/data memory of the single-issue core.

---
 rtl/ctrl_seq.sv | 188 ++++++++++++++++++
 tb/tb_ctrl_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq.sv
// Sequenced control decoder: registered control vector, LOD memory wait, branch flush, illegal detect.
// Latency: control for an instruction accepted in cycle N is presented in cycle N+1.
// Backpressure: o_instr_ready drops (and o_pc_stall rises) during MEM_WAIT; ready drops during FLUSH.
module ctrl_seq #(
  parameter int OPW         = 4,
  parameter int MEM_LAT     = 2,
  parameter int FLUSH_SLOTS = 1
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_instr_valid,
  input  logic [2:0]     i_opcode,
  input  logic [3:0]     i_mode,
  input  logic           i_zero_flag,
  input  logic           i_neg_flag,
  output logic           o_instr_ready,
  output logic           o_ctrl_valid,
  output logic           o_trunc_reg,
  output logic           o_trunc_prefix,
  output logic           o_parity_op,
  output logic           o_mem_to_reg,
  output logic           o_mem_write,
  output logic           o_reg_write,
  output logic [1:0]     o_second_operand,
  output logic [OPW-1:0] o_alu_op,
  output logic           o_branch_abs,
  output logic           o_branch_rel,
  output logic           o_pc_stall,
  output logic           o_illegal
);

  if (OPW < 4) begin : g_bad_opw
    $error("ctrl_seq: OPW must be at least 4");
  end
  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("ctrl_seq: MEM_LAT must be in 1..15");
  end
  if (FLUSH_SLOTS < 0 || FLUSH_SLOTS > 3) begin : g_bad_flush
    $error("ctrl_seq: FLUSH_SLOTS must be in 0..3");
  end

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_FLUSH} state_t;

  typedef struct packed {
    logic       ctrl_valid;
    logic       trunc_reg;
    logic       trunc_prefix;
    logic       parity_op;
    logic       mem_to_reg;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] second_operand;
    logic [3:0] alu;
    logic       branch_abs;
    logic       branch_rel;
    logic       illegal;
  } ctrl_t;

  // Counter counts remaining MEM_WAIT/FLUSH cycles after the current one; zero means last.
  localparam logic [3:0] LP_WAIT_LOAD  = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;
  localparam logic [3:0] LP_FLUSH_LOAD = (FLUSH_SLOTS > 0) ? 4'(FLUSH_SLOTS - 1) : 4'd0;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  ctrl_t      r_ctrl, w_ctrl_nxt;
  logic       w_taken;

  // State, counter and the registered control vector; reset returns to the idle vector.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state                <= S_RUN;
      r_cnt                  <= 4'd0;
      r_ctrl                 <= '0;
      r_ctrl.second_operand  <= 2'b01;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ctrl  <= w_ctrl_nxt;
    end
  end

  // Next state and next control vector: decode in RUN, hold the LOD vector in MEM_WAIT, idle in FLUSH.
  always_comb begin
    w_state_nxt               = r_state;
    w_cnt_nxt                 = r_cnt;
    w_ctrl_nxt                = '0;
    w_ctrl_nxt.second_operand = 2'b01;
    w_taken                   = (i_mode[1] ? i_neg_flag : i_zero_flag) ^ i_mode[2];
    unique case (r_state)
      S_RUN: begin
        if (i_instr_valid) begin
          w_ctrl_nxt.ctrl_valid = 1'b1;
          w_ctrl_nxt.reg_write  = 1'b1;
          unique case (i_opcode)
            3'b000: w_ctrl_nxt.alu = 4'b0000;
            3'b001: w_ctrl_nxt.alu = 4'b0001;
            3'b010: w_ctrl_nxt.alu = 4'b0010;
            3'b011: begin
              w_ctrl_nxt.alu            = 4'b0001;
              w_ctrl_nxt.trunc_reg      = 1'b1;
              w_ctrl_nxt.second_operand = 2'b00;
              if (i_mode[3]) begin
                w_ctrl_nxt.mem_write = 1'b1;
                w_ctrl_nxt.reg_write = 1'b0;
              end else begin
                w_ctrl_nxt.mem_to_reg = 1'b1;
                if (MEM_LAT > 1) begin
                  w_ctrl_nxt.reg_write = 1'b0;
                  w_state_nxt          = S_MEM_WAIT;
                  w_cnt_nxt            = LP_WAIT_LOAD;
                end
              end
            end
            3'b100: begin
              w_ctrl_nxt.alu            = 4'b0000;
              w_ctrl_nxt.trunc_reg      = 1'b1;
              w_ctrl_nxt.trunc_prefix   = 1'b1;
              w_ctrl_nxt.second_operand = 2'b10;
            end
            3'b101: begin
              unique case (i_mode[2:0])
                3'b000: w_ctrl_nxt.alu = 4'b0100;
                3'b010: w_ctrl_nxt.alu = 4'b0101;
                3'b011: w_ctrl_nxt.alu = 4'b0011;
                3'b100: w_ctrl_nxt.alu = 4'b0110;
                3'b110: w_ctrl_nxt.alu = 4'b0111;
                default: begin
                  w_ctrl_nxt.illegal   = 1'b1;
                  w_ctrl_nxt.reg_write = 1'b0;
                end
              endcase
            end
            3'b110: begin
              w_ctrl_nxt.reg_write      = 1'b0;
              w_ctrl_nxt.second_operand = 2'b00;
              if (w_taken) begin
                w_ctrl_nxt.branch_abs = i_mode[0];
                w_ctrl_nxt.branch_rel = ~i_mode[0];
                if (FLUSH_SLOTS > 0) begin
                  w_state_nxt = S_FLUSH;
                  w_cnt_nxt   = LP_FLUSH_LOAD;
                end
              end
            end
            default: begin
              w_ctrl_nxt.parity_op = 1'b1;
              w_ctrl_nxt.alu       = {1'b1, i_mode[2:0]};
            end
          endcase
        end
      end
      S_MEM_WAIT: begin
        w_ctrl_nxt = r_ctrl;
        if (r_cnt == 4'd0) begin
          w_ctrl_nxt.reg_write = 1'b1;
          w_state_nxt          = S_RUN;
        end else begin
          w_ctrl_nxt.reg_write = 1'b0;
          w_cnt_nxt            = r_cnt - 4'd1;
        end
      end
      S_FLUSH: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  assign o_instr_ready    = (r_state == S_RUN);
  assign o_pc_stall       = (r_state == S_MEM_WAIT);
  assign o_ctrl_valid     = r_ctrl.ctrl_valid;
  assign o_trunc_reg      = r_ctrl.trunc_reg;
  assign o_trunc_prefix   = r_ctrl.trunc_prefix;
  assign o_parity_op      = r_ctrl.parity_op;
  assign o_mem_to_reg     = r_ctrl.mem_to_reg;
  assign o_mem_write      = r_ctrl.mem_write;
  assign o_reg_write      = r_ctrl.reg_write;
  assign o_second_operand = r_ctrl.second_operand;
  assign o_alu_op         = OPW'(r_ctrl.alu);
  assign o_branch_abs     = r_ctrl.branch_abs;
  assign o_branch_rel     = r_ctrl.branch_rel;
  assign o_illegal        = r_ctrl.illegal;

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: directed table, hand-written multi-cycle sequences, random stimulus vs timeline model.
module tb_ctrl_seq;
  localparam int OPW  = 4;
  localparam int ML   = 3;
  localparam int FS   = 1;
  localparam int MAXC = 2048;

  logic       clk = 1'b0;
  logic       rst, v, z, n;
  logic [2:0] op;
  logic [3:0] mode;
  logic       o_instr_ready, o_ctrl_valid, o_trunc_reg, o_trunc_prefix, o_parity_op;
  logic       o_mem_to_reg, o_mem_write, o_reg_write, o_branch_abs, o_branch_rel;
  logic       o_pc_stall, o_illegal;
  logic [1:0] o_second_operand;
  logic [OPW-1:0] o_alu_op;

  ctrl_seq #(.OPW(OPW), .MEM_LAT(ML), .FLUSH_SLOTS(FS)) dut (
    .i_clk(clk), .i_reset(rst), .i_instr_valid(v), .i_opcode(op), .i_mode(mode),
    .i_zero_flag(z), .i_neg_flag(n), .o_instr_ready(o_instr_ready),
    .o_ctrl_valid(o_ctrl_valid), .o_trunc_reg(o_trunc_reg), .o_trunc_prefix(o_trunc_prefix),
    .o_parity_op(o_parity_op), .o_mem_to_reg(o_mem_to_reg), .o_mem_write(o_mem_write),
    .o_reg_write(o_reg_write), .o_second_operand(o_second_operand), .o_alu_op(o_alu_op),
    .o_branch_abs(o_branch_abs), .o_branch_rel(o_branch_rel), .o_pc_stall(o_pc_stall),
    .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic cv, tr, tp, par, m2r, mw, rw;
    logic [1:0] so;
    logic [3:0] alu;
    logic ba, br, ill;
  } cv_t;

  typedef struct packed {
    logic v;
    logic [2:0] op;
    logic [3:0] md;
    logic z, n;
    cv_t e;
  } row_t;

  // Bit groups: cv | tr tp par m2r | mw | rw | so | alu | ba br ill
  localparam cv_t IDLE = 16'b0_0000_0_0_01_0000_000;

  cv_t dut_v;
  assign dut_v = {o_ctrl_valid, o_trunc_reg, o_trunc_prefix, o_parity_op, o_mem_to_reg,
                  o_mem_write, o_reg_write, o_second_operand, o_alu_op, o_branch_abs,
                  o_branch_rel, o_illegal};

  int  checks = 0;
  int  errors = 0;
  int  cyc;
  int  next_acc;
  int  stall_end;
  cv_t exp_vec [MAXC];
  row_t tbl[$];

  task automatic chk16(input string nm, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, a, e);
    end
  endtask

  task automatic chk1(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, a, e);
    end
  endtask

  // Control vector an accepted instruction produces on its first output cycle.
  function automatic cv_t decode(input logic [2:0] o, input logic [3:0] md, input logic zf, input logic nf);
    cv_t d = IDLE;
    d.cv = 1'b1;
    d.rw = 1'b1;
    case (o)
      3'd1: d.alu = 4'd1;
      3'd2: d.alu = 4'd2;
      3'd3: begin
        d.alu = 4'd1; d.tr = 1'b1; d.so = 2'b00;
        if (md[3]) begin d.mw = 1'b1; d.rw = 1'b0; end
        else d.m2r = 1'b1;
      end
      3'd4: begin d.tr = 1'b1; d.tp = 1'b1; d.so = 2'b10; end
      3'd5: case (md[2:0])
        3'd0: d.alu = 4'b0100;
        3'd2: d.alu = 4'b0101;
        3'd3: d.alu = 4'b0011;
        3'd4: d.alu = 4'b0110;
        3'd6: d.alu = 4'b0111;
        default: begin d.ill = 1'b1; d.rw = 1'b0; end
      endcase
      3'd6: begin
        d.rw = 1'b0; d.so = 2'b00;
        if ((md[1] ? nf : zf) ^ md[2]) begin d.ba = md[0]; d.br = ~md[0]; end
      end
      3'd7: begin d.par = 1'b1; d.alu = {1'b1, md[2:0]}; end
      default: ;
    endcase
    return d;
  endfunction

  // Compare this cycle against the timeline, update the timeline with this cycle's inputs, advance.
  task automatic tick();
    cv_t d;
    chk16("vector", dut_v, exp_vec[cyc]);
    chk1("ready", o_instr_ready, cyc >= next_acc);
    chk1("stall", o_pc_stall, cyc < stall_end);
    if (rst) begin
      for (int i = cyc + 1; i < MAXC; i++) exp_vec[i] = IDLE;
      next_acc  = cyc + 1;
      stall_end = 0;
    end else if (v && cyc >= next_acc) begin
      d = decode(op, mode, z, n);
      if (op == 3'd3 && !mode[3]) begin
        for (int k = 1; k <= ML; k++) begin
          exp_vec[cyc + k]    = d;
          exp_vec[cyc + k].rw = (k == ML);
        end
        next_acc  = cyc + ML;
        stall_end = cyc + ML;
      end else begin
        exp_vec[cyc + 1] = d;
        if (d.ba || d.br) next_acc = cyc + 1 + FS;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; v = 1'b0; op = 3'd0; mode = 4'd0; z = 1'b0; n = 1'b0;
    cyc = 0; next_acc = 0; stall_end = 0;
    for (int i = 0; i < MAXC; i++) exp_vec[i] = IDLE;
    repeat (2) @(posedge clk);
    #1;
    chk16("reset_vector", dut_v, IDLE);
    chk1("reset_ready", o_instr_ready, 1'b1);
    chk1("reset_stall", o_pc_stall, 1'b0);
    tick();
    rst = 1'b0;

    // Single-cycle instructions: {valid, opcode, mode, zero, neg, expected next-cycle vector}
    tbl.push_back({1'b1, 3'd0, 4'b0000, 1'b0, 1'b0, 16'b1_0000_0_1_01_0000_000});
    tbl.push_back({1'b1, 3'd1, 4'b0000, 1'b0, 1'b0, 16'b1_0000_0_1_01_0001_000});
    tbl.push_back({1'b1, 3'd2, 4'b0000, 1'b0, 1'b0, 16'b1_0000_0_1_01_0010_000});
    tbl.push_back({1'b1, 3'd3, 4'b1000, 1'b0, 1'b0, 16'b1_1000_1_0_00_0001_000});
    tbl.push_back({1'b1, 3'd4, 4'b0000, 1'b0, 1'b0, 16'b1_1100_0_1_10_0000_000});
    tbl.push_back({1'b1, 3'd5, 4'b0000, 1'b0, 1'b0, 16'b1_0000_0_1_01_0100_000});
    tbl.push_back({1'b1, 3'd5, 4'b0010, 1'b0, 1'b0, 16'b1_0000_0_1_01_0101_000});
    tbl.push_back({1'b1, 3'd5, 4'b1011, 1'b0, 1'b0, 16'b1_0000_0_1_01_0011_000});
    tbl.push_back({1'b1, 3'd5, 4'b0100, 1'b0, 1'b0, 16'b1_0000_0_1_01_0110_000});
    tbl.push_back({1'b1, 3'd5, 4'b0110, 1'b0, 1'b0, 16'b1_0000_0_1_01_0111_000});
    tbl.push_back({1'b1, 3'd5, 4'b0101, 1'b0, 1'b0, 16'b1_0000_0_0_01_0000_001});
    tbl.push_back({1'b1, 3'd5, 4'b1001, 1'b0, 1'b0, 16'b1_0000_0_0_01_0000_001});
    tbl.push_back({1'b1, 3'd5, 4'b0111, 1'b0, 1'b0, 16'b1_0000_0_0_01_0000_001});
    tbl.push_back({1'b1, 3'd7, 4'b0110, 1'b0, 1'b0, 16'b1_0010_0_1_01_1110_000});
    tbl.push_back({1'b1, 3'd6, 4'b0011, 1'b1, 1'b0, 16'b1_0000_0_0_00_0000_000});
    tbl.push_back({1'b1, 3'd6, 4'b0100, 1'b1, 1'b1, 16'b1_0000_0_0_00_0000_000});
    tbl.push_back({1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 16'b0_0000_0_0_01_0000_000});
    foreach (tbl[i]) begin
      v = tbl[i].v; op = tbl[i].op; mode = tbl[i].md; z = tbl[i].z; n = tbl[i].n;
      tick();
      chk16($sformatf("table_row%0d", i), dut_v, tbl[i].e);
    end
    v = 1'b0;
    tick();

    // LOD: stall for ML-1 cycles, write-back only on the last cycle, ADD accepted on that cycle.
    v = 1'b1; op = 3'd3; mode = 4'b0101;
    tick();
    op = 3'd0; mode = 4'b0000;
    for (int k = 1; k <= ML; k++) begin
      chk1($sformatf("lod_m2r_k%0d", k), o_mem_to_reg, 1'b1);
      chk1($sformatf("lod_rw_k%0d", k), o_reg_write, k == ML);
      chk1($sformatf("lod_stall_k%0d", k), o_pc_stall, k < ML);
      chk1($sformatf("lod_ready_k%0d", k), o_instr_ready, k == ML);
      tick();
    end
    chk16("lod_next_add", dut_v, 16'b1_0000_0_1_01_0000_000);
    v = 1'b0;
    tick();

    // Taken absolute branch on neg flag: pulse, one ignored instruction, resume.
    v = 1'b1; op = 3'd6; mode = 4'b0011; z = 1'b0; n = 1'b1;
    tick();
    chk1("br_abs_pulse", o_branch_abs, 1'b1);
    chk1("br_rel_quiet", o_branch_rel, 1'b0);
    chk1("br_flush_ready", o_instr_ready, 1'b0);
    chk1("br_flush_stall", o_pc_stall, 1'b0);
    op = 3'd1; n = 1'b0;
    tick();
    chk1("br_ignored_instr", o_ctrl_valid, 1'b0);
    chk1("br_abs_once", o_branch_abs, 1'b0);
    op = 3'd2;
    tick();
    chk16("br_resume_and", dut_v, 16'b1_0000_0_1_01_0010_000);
    v = 1'b0;
    tick();

    // Reset during the second MEM_WAIT cycle aborts the load.
    v = 1'b1; op = 3'd3; mode = 4'b0000;
    tick();
    v = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk16("abort_vector", dut_v, IDLE);
    chk1("abort_ready", o_instr_ready, 1'b1);
    repeat (3) begin
      chk1("abort_no_rw", o_reg_write, 1'b0);
      tick();
    end

    // Random traffic against the timeline model.
    repeat (400) begin
      v    = ($urandom_range(0, 3) != 0);
      op   = 3'($urandom_range(0, 7));
      mode = 4'($urandom_range(0, 15));
      z    = 1'($urandom_range(0, 1));
      n    = 1'($urandom_range(0, 1));
      rst  = ($urandom_range(0, 63) == 0);
      tick();
    end
    v = 1'b0; rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
